// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// op encodings, FSM states, iteration-count width and op decode helpers.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam int ITER_W       = $clog2(MULDIV_WIDTH);

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/pipe_muldiv_ctrl_if.sv
// Decode/EX boundary bundle for the mul/div sequencer: request side is the
// master (pipeline), the sequencer is the slave.
interface pipe_muldiv_ctrl_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wd;
  logic             rd_hi;
  logic             rd_lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, rs_val, rt_val, mthi, mtlo, wd, rd_hi, rd_lo,
    input  hi, lo, busy, stall, done, div_zero
  );

  modport slave (
    input  start, op, rs_val, rt_val, mthi, mtlo, wd, rd_hi, rd_lo,
    output hi, lo, busy, stall, done, div_zero
  );
endinterface

// File: rtl/muldiv_core.sv
// Unsigned shift-add multiply / restoring divide datapath, one step per
// enabled cycle. {res_hi,res_lo} is the product, or remainder/quotient.
module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             load_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] m_r;
  logic             div_r;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH+1:0] div_diff_s;
  logic [WIDTH-1:0] hi_nxt_s;
  logic [WIDTH-1:0] lo_nxt_s;
  logic             diff_unused_s;

  // Bit WIDTH of a non-borrowing difference is always zero (rem < divisor).
  assign diff_unused_s = div_diff_s[WIDTH];

  // One multiply or restoring-divide iteration.
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {hi_r, lo_r[WIDTH-1]};
    div_diff_s  = {1'b0, div_shift_s} - {2'b00, m_r};
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    if (div_r) begin
      if (!div_diff_s[WIDTH+1]) begin
        hi_nxt_s = div_diff_s[WIDTH-1:0];
        lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt_s = div_shift_s[WIDTH-1:0];
        lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt_s = mul_sum_s[WIDTH:1];
      lo_nxt_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Operand load and per-cycle shift register update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_r  <= '0;
      lo_r  <= '0;
      m_r   <= '0;
      div_r <= 1'b0;
    end else if (load) begin
      div_r <= load_div;
      hi_r  <= '0;
      lo_r  <= load_div ? a : b;
      m_r   <= load_div ? b : a;
    end else if (step) begin
      hi_r <= hi_nxt_s;
      lo_r <= lo_nxt_s;
    end
  end

  assign res_hi = hi_r;
  assign res_lo = lo_r;

endmodule

// File: rtl/pipe_muldiv_ctrl.sv
// Mul/div sequencer: FSM, iteration counter, sign fix-up, HI/LO and stall.
// Signed MULT/DIV handling is present only when MULDIV_SIGNED_EN is defined.
module pipe_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  pipe_muldiv_ctrl_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             load_s;
  logic             step_s;
  logic             fix_s;
  logic             dz_in_s;
  logic             dz_r;
  logic             busy_r;
  logic             done_r;
  logic             div_zero_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH-1:0] core_hi_s;
  logic [WIDTH-1:0] core_lo_s;
  logic [WIDTH-1:0] fix_hi_s;
  logic [WIDTH-1:0] fix_lo_s;

  assign dz_in_s = op_is_div(bus.op) && (bus.rt_val == '0);

`ifdef MULDIV_SIGNED_EN
  logic               a_neg_s;
  logic               b_neg_s;
  logic               is_div_r;
  logic               neg_res_r;
  logic               neg_rem_r;
  logic [2*WIDTH-1:0] prod_s;

  // Magnitude conversion of signed operands before they enter the datapath.
  always_comb begin
    a_neg_s = op_is_signed(bus.op) & bus.rs_val[WIDTH-1];
    b_neg_s = op_is_signed(bus.op) & bus.rt_val[WIDTH-1];
    if (a_neg_s) a_mag_s = -bus.rs_val;
    else         a_mag_s = bus.rs_val;
    if (b_neg_s) b_mag_s = -bus.rt_val;
    else         b_mag_s = bus.rt_val;
  end

  // Result sign flags captured with the operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
    end else if (load_s) begin
      is_div_r  <= op_is_div(bus.op);
      neg_res_r <= a_neg_s ^ b_neg_s;
      neg_rem_r <= a_neg_s;
    end
  end

  // Sign correction; the divide-by-zero HI restores rs_val from its magnitude.
  always_comb begin
    prod_s   = {core_hi_s, core_lo_s};
    fix_hi_s = core_hi_s;
    fix_lo_s = core_lo_s;
    if (dz_r) begin
      fix_hi_s = neg_rem_r ? -core_lo_s : core_lo_s;
      fix_lo_s = '1;
    end else if (is_div_r) begin
      fix_hi_s = neg_rem_r ? -core_hi_s : core_hi_s;
      fix_lo_s = neg_res_r ? -core_lo_s : core_lo_s;
    end else if (neg_res_r) begin
      {fix_hi_s, fix_lo_s} = -prod_s;
    end else begin
      {fix_hi_s, fix_lo_s} = prod_s;
    end
  end
`else
  assign a_mag_s = bus.rs_val;
  assign b_mag_s = bus.rt_val;

  // Unsigned writeback; divide-by-zero HI is the untouched dividend.
  always_comb begin
    if (dz_r) begin
      fix_hi_s = core_lo_s;
      fix_lo_s = '1;
    end else begin
      fix_hi_s = core_hi_s;
      fix_lo_s = core_lo_s;
    end
  end
`endif

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .load_div (op_is_div(bus.op)),
    .step     (step_s),
    .a        (a_mag_s),
    .b        (b_mag_s),
    .res_hi   (core_hi_s),
    .res_lo   (core_lo_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next state and datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    fix_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          load_s = 1'b1;
          if (dz_in_s) state_nxt_s = FIX;
          else         state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == '0) state_nxt_s = FIX;
        else             state_nxt_s = RUN;
      end
      FIX: begin
        fix_s       = 1'b1;
        state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Counter, busy/done and the sticky divide-by-zero flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r      <= '0;
      dz_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r <= fix_s;
      if (load_s) begin
        cnt_r      <= CNT_LAST;
        dz_r       <= dz_in_s;
        div_zero_r <= dz_in_s;
        busy_r     <= 1'b1;
      end else if (step_s) begin
        cnt_r <= cnt_r - CNT_ONE;
      end else if (fix_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  // HI/LO: op results at FIX, MTHI/MTLO only while idle (stalled otherwise).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (fix_s) begin
      hi_r <= fix_hi_s;
      lo_r <= fix_lo_s;
    end else if (state_r == IDLE) begin
      if (bus.mthi) hi_r <= bus.wd;
      if (bus.mtlo) lo_r <= bus.wd;
    end
  end

  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.stall    = busy_r & (bus.start | bus.rd_hi | bus.rd_lo | bus.mthi | bus.mtlo);

endmodule

// File: tb/tb_pipe_muldiv_ctrl.sv
// Directed bench for pipe_muldiv_ctrl with a result scoreboard; expected
// values follow MULDIV_SIGNED_EN in the same way as the design build.
module tb_pipe_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [64:0] sb_q[$];

  pipe_muldiv_ctrl_if #(.WIDTH(32)) bus();
  pipe_muldiv_ctrl #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {div_zero, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    longint sa, sb;
    logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
    sgn = o[0];
`else
    sgn = 1'b0;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o[1] == 1'b0) begin
      if (sgn) p = 64'(sa * sb);
      else     p = {32'd0, a} * {32'd0, b};
      return {1'b0, p};
    end else if (b == 32'd0) begin
      return {1'b1, a, 32'hFFFF_FFFF};
    end else if (sgn) begin
      return {1'b0, 32'(sa % sb), 32'(sa / sb)};
    end else begin
      return {1'b0, a % b, a / b};
    end
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit mt);
    logic [64:0] e;
    int cyc;
    e = model(o, a, b);
    sb_q.push_back(e);
    if (mt) begin
      bus.mthi = 1'b1;
      bus.wd   = 32'hCAFE_F00D;
    end
    bus.op = o; bus.rs_val = a; bus.rt_val = b; bus.start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
      cyc++;
      if (cyc == 1) begin
        chk({tag, " busy@1"}, 64'(bus.busy), 64'd1);
        chk({tag, " div_zero@1"}, 64'(bus.div_zero), 64'(e[64]));
        if (mt) chk({tag, " mthi_with_start"}, 64'(bus.hi), 64'h0000_0000_CAFE_F00D);
      end
      if (cyc == 33) chk({tag, " busy@33"}, 64'(bus.busy), 64'd1);
    end while (!bus.done && cyc < 100);
    chk({tag, " latency"}, 64'(cyc), e[64] ? 64'd2 : 64'd34);
    e = sb_q.pop_front();
    chk({tag, " hi"}, 64'(bus.hi), 64'(e[63:32]));
    chk({tag, " lo"}, 64'(bus.lo), 64'(e[31:0]));
    chk({tag, " busy_done"}, 64'(bus.busy), 64'd0);
    chk({tag, " div_zero"}, 64'(bus.div_zero), 64'(e[64]));
  endtask

  initial begin
    logic [64:0] e;
    int cyc;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = 32'd0; bus.rt_val = 32'd0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wd = 32'd0; bus.rd_hi = 1'b0; bus.rd_lo = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset flags", 64'({bus.busy, bus.stall, bus.done, bus.div_zero}), 64'd0);
    rst_n = 1'b1;

    // MTHI/MTLO and MFHI while idle
    bus.mthi = 1'b1; bus.wd = 32'h1234_5678;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wd = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.mtlo = 1'b0;
    chk("mt hilo", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);
    bus.rd_hi = 1'b1;
    #1;
    chk("idle rd_hi stall", 64'(bus.stall), 64'd0);
    chk("idle rd_hi hi", 64'(bus.hi), 64'h1234_5678);
    bus.rd_hi = 1'b0;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         "mult_m3x7", 1'b0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         "div_m7d2", 1'b0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_minneg", 1'b0);
    run_op(OP_DIVU,  32'd100,       32'd0,         "divu_zero", 1'b0);
    run_op(OP_MULTU, 32'd5,         32'd6,         "multu_5x6", 1'b0);
    run_op(OP_DIVU,  32'd1000,      32'd7,         "divu_1000d7", 1'b1);
    run_op(OP_DIV,   32'd50,        32'hFFFF_FFF9, "div_50dm7", 1'b0);

    // MFLO requested 5 cycles into an op: stall until the result lands
    e = model(OP_MULTU, 32'h0001_0000, 32'h0003_0001);
    sb_q.push_back(e);
    bus.op = OP_MULTU; bus.rs_val = 32'h0001_0000; bus.rt_val = 32'h0003_0001; bus.start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
      if (cyc == 5) bus.rd_lo = 1'b1;
      if (cyc == 6 || cyc == 33) chk("mflo stall busy", 64'(bus.stall), 64'd1);
    end while (!bus.done && cyc < 100);
    e = sb_q.pop_front();
    chk("mflo latency", 64'(cyc), 64'd34);
    chk("mflo stall after", 64'(bus.stall), 64'd0);
    chk("mflo lo", 64'(bus.lo), 64'(e[31:0]));
    bus.rd_lo = 1'b0;
    @(negedge clk);
    chk("done one pulse", 64'(bus.done), 64'd0);

    // Reset during RUN aborts the op
    bus.op = OP_MULTU; bus.rs_val = 32'd123; bus.rt_val = 32'd456; bus.start = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort flags", 64'({bus.busy, bus.done, bus.div_zero}), 64'd0);
    chk("abort hilo", {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(OP_DIVU, 32'hDEAD_BEEF, 32'd3, "after_abort", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_muldiv_ctrl.md
# pipe_muldiv_ctrl

Iterative multiply/divide sequencer with a HI/LO register pair. It sits beside the EX-stage ALU and accepts MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO traffic from the decode/EX boundary. It runs a 32-iteration shift-add / restoring-division state machine and drives a stall to the pipeline while results are pending.

## Interface
Parameters:
- WIDTH, 32, operand/HI/LO width (iteration count = WIDTH)

Ports. One clock; reset is synchronous and active-low.
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  issue a mul/div op this cycle
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- rs_val  in  WIDTH  multiplicand / dividend
- rt_val  in  WIDTH  multiplier / divisor
- mthi  in  1  write wd to HI
- mtlo  in  1  write wd to LO
- wd  in  WIDTH  MTHI/MTLO data
- rd_hi  in  1  EX stage wants HI (MFHI)
- rd_lo  in  1  EX stage wants LO (MFLO)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  operation in flight
- stall  out  1  hold IF/ID/EX this cycle
- done  out  1  one-cycle pulse when HI/LO are written by an op
- div_zero  out  1  sticky; set by a DIV/DIVU with rt_val==0, cleared by the next accepted start

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1: latch |operands| (signed ops) or raw operands, result-sign flags, and op. Load counter=WIDTH-1.
  - Next state RUN.
  - Exception: a divide with rt_val==0 goes directly to FIX and sets div_zero.
- RUN:
  - Multiply: shift-add one bit per cycle into a 2*WIDTH accumulator.
  - Divide: one restoring step per cycle (shift remainder, trial subtract, set quotient bit).
  - Counter decrements; at counter==0 the next state is FIX.
- FIX:
  - Apply sign correction.
  - Product: negate the 64-bit result if operand signs differ.
  - Quotient: negate if signs differ. Remainder takes the dividend's sign.
  - Write HI/LO; pulse done; next state IDLE.
- Divide-by-zero result: LO=all-ones, HI=rs_val.
- -2^31 / -1 (DIV) gives LO=0x80000000, HI=0. No trap.
- Writeback mapping: multiply gives HI=upper, LO=lower. Divide gives LO=quotient, HI=remainder.
- stall = busy & (start | rd_hi | rd_lo | mthi | mtlo).
  - While stalled, inputs are held by the pipeline; the request is not acted on.
  - start while busy is not accepted.
- MTHI/MTLO in IDLE: write on that edge.
  - If start is also asserted in the same cycle, the MT write applies and the op starts. The op's FIX later overwrites HI/LO.
- rd_hi/rd_lo in IDLE: no stall; hi/lo are read combinationally from the registers.
- Reset values: hi=0, lo=0, busy=0, stall=0, done=0, div_zero=0, state IDLE, counter 0.
- Reset mid-operation aborts; HI/LO return to 0.

## Timing
- start sampled at edge E0.
- busy=1 from E0 through the FIX edge: RUN occupies E1..E32, FIX writes at E33.
- hi/lo are new and done=1 in the cycle after E33; busy=0 in that cycle.
- Total latency 34 cycles: start edge to first cycle with valid HI/LO.
- Divide-by-zero: FIX at E1, result visible after E1 (2 cycles).
- A back-to-back start is accepted in the done cycle.
- stall is combinational from busy and requests; no registered delay.

## Configuration
- MULDIV_SIGNED_EN defined:
  - MULT/DIV use signed magnitude conversion and the FIX sign correction above.
- MULDIV_SIGNED_EN undefined:
  - op[0] is ignored; MULT≡MULTU and DIV≡DIVU.
  - No negation logic; FIX only writes HI/LO.
  - Latency is unchanged.

## Structure
- Package muldiv_pkg:
  - op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV
  - state enum: IDLE, RUN, FIX
  - ITER_W = $clog2(WIDTH)
- Sub-module muldiv_core:
  - Pure datapath: accumulator/remainder shift registers and one add/subtract step per enable.
  - pipe_muldiv_ctrl owns the FSM, counter, sign flags, HI/LO and stall.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - HI=0xFFFFFFFE, LO=0x00000001.
  - done exactly 34 cycles after start; busy high E0..E33.
- MULT −3 × 7:
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - Without MULDIV_SIGNED_EN: HI=0x00000006, LO=0xFFFFFFEB.
- DIV −7 / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0:
  - LO=0xFFFFFFFF, HI=100, div_zero=1, done 2 cycles after start.
  - div_zero clears on the next start.
- MFLO issued 5 cycles after start:
  - stall=1 until busy falls; the cycle after FIX, stall=0 and lo shows the new result.
- rst_n low at RUN cycle 10: next cycle busy=0, hi=lo=0, state IDLE; a new start completes normally.
